// File: rtl/pipe_ctrl_scoreboard.sv
// RV32I pipeline control: per-stage decode, RAW scoreboard, branch flush.
// Optional macro PIPE_FWD_EN: datapath forwards, only load-use stalls.
module pipe_ctrl_scoreboard #(
    parameter int STAGES   = 4,
    parameter int BR_STAGE = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ins_valid,
    input  logic [31:0] ins,
    output logic        ins_ready,
    input  logic        branch_taken,
    output logic        flush,
    output logic        illegal_ins,
    output logic [2:0]  immode,
    output logic [1:0]  a_sel,
    output logic [1:0]  b_sel,
    output logic [3:0]  alu_mode,
    output logic [1:0]  branch_cond,
    output logic [2:0]  data_mode,
    output logic        dcache_en,
    output logic        dcache_rw,
    output logic [2:0]  wbs,
    output logic        wbe,
    output logic [4:0]  wb_rd
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I1    = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_NOP   = 7'b0000000;
    localparam logic [6:0] OP_FENCE = 7'b0001111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    function automatic logic legal_op(input logic [6:0] op);
        case (op)
            OP_R, OP_I1, OP_LD, OP_JALR, OP_S, OP_B,
            OP_LUI, OP_AUIPC, OP_JAL,
            OP_NOP, OP_FENCE, OP_SYS: legal_op = 1'b1;
            default:                  legal_op = 1'b0;
        endcase
    endfunction

    function automatic logic writer_op(input logic [6:0] op);
        case (op)
            OP_R, OP_I1, OP_LD, OP_JALR,
            OP_LUI, OP_AUIPC, OP_JAL: writer_op = 1'b1;
            default:                  writer_op = 1'b0;
        endcase
    endfunction

    function automatic logic rs1_op(input logic [6:0] op);
        case (op)
            OP_R, OP_I1, OP_LD, OP_JALR,
            OP_S, OP_B: rs1_op = 1'b1;
            default:    rs1_op = 1'b0;
        endcase
    endfunction

    function automatic logic rs2_op(input logic [6:0] op);
        case (op)
            OP_R, OP_S, OP_B: rs2_op = 1'b1;
            default:          rs2_op = 1'b0;
        endcase
    endfunction

    // rd of an older writer against the true sources of the incoming op
    function automatic logic src_hit(
        input logic [4:0] rd,
        input logic [6:0] op,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        src_hit = (rs1_op(op) && rs1 == rd) ||
                  (rs2_op(op) && rs2 == rd);
    endfunction

    logic [31:0]       ins_q [STAGES];
    logic [STAGES-1:0] v_q;
    logic              hazard;

    logic [6:0] op0, op1, op2, opw;
    logic [2:0] f3_1, f3_2, f3_w;
    logic       b30_1;
    logic [4:0] rd_w;

    // invalid stages decode as an all-zero NOP
    assign op0   = v_q[0] ? ins_q[0][6:0] : 7'd0;
    assign op1   = v_q[1] ? ins_q[1][6:0] : 7'd0;
    assign f3_1  = v_q[1] ? ins_q[1][14:12] : 3'd0;
    assign b30_1 = v_q[1] & ins_q[1][30];
    assign op2   = v_q[2] ? ins_q[2][6:0] : 7'd0;
    assign f3_2  = v_q[2] ? ins_q[2][14:12] : 3'd0;
    assign opw   = v_q[STAGES-1] ? ins_q[STAGES-1][6:0] : 7'd0;
    assign f3_w  = v_q[STAGES-1] ? ins_q[STAGES-1][14:12] : 3'd0;
    assign rd_w  = v_q[STAGES-1] ? ins_q[STAGES-1][11:7] : 5'd0;

    // RAW detection against in-flight writers (WB excluded)
    always_comb begin
        hazard = 1'b0;
`ifdef PIPE_FWD_EN
        if (v_q[0] && ins_q[0][6:0] == OP_LD &&
            ins_q[0][11:7] != 5'd0 &&
            src_hit(ins_q[0][11:7], ins[6:0],
                    ins[19:15], ins[24:20]))
            hazard = 1'b1;
`else
        for (int k = 0; k < STAGES-1; k++) begin
            if (v_q[k] && writer_op(ins_q[k][6:0]) &&
                ins_q[k][11:7] != 5'd0 &&
                src_hit(ins_q[k][11:7], ins[6:0],
                        ins[19:15], ins[24:20]))
                hazard = 1'b1;
        end
`endif
        hazard = hazard & ins_valid;
    end

    // taken control transfer in the branch stage redirects fetch
    always_comb begin
        flush = 1'b0;
        if (v_q[BR_STAGE] && branch_taken) begin
            case (ins_q[BR_STAGE][6:0])
                OP_B, OP_JALR, OP_JAL: flush = 1'b1;
                default:               flush = 1'b0;
            endcase
        end
        ins_ready   = !flush && !hazard;
        illegal_ins = ins_valid && !legal_op(ins[6:0]);
    end

    // stage advance: flush kills young stages, stall bubbles stage 0
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < STAGES; k++)
                ins_q[k] <= 32'd0;
            v_q <= '0;
        end else begin
            for (int k = STAGES-1; k > 0; k--) begin
                ins_q[k] <= ins_q[k-1];
                v_q[k]   <= v_q[k-1] && !(flush && k <= BR_STAGE);
            end
            ins_q[0] <= ins;
            v_q[0]   <= ins_ready && ins_valid &&
                        legal_op(ins[6:0]);
        end
    end

    // immediate format of the incoming instruction
    always_comb begin
        case (ins[6:0])
            OP_R:                   immode = 3'd0;
            OP_I1, OP_LD, OP_JALR:  immode = 3'd1;
            OP_S:                   immode = 3'd2;
            OP_B:                   immode = 3'd3;
            OP_LUI, OP_AUIPC:       immode = 3'd4;
            OP_JAL:                 immode = 3'd5;
            default:                immode = 3'd0;
        endcase
    end

    // ID operand selects
    always_comb begin
        a_sel = 2'b00;
        b_sel = 2'b00;
        case (op0)
            OP_I1: b_sel = 2'b01;
            OP_JALR, OP_JAL: begin
                a_sel = 2'b01;
                b_sel = 2'b10;
            end
            OP_LUI: begin
                a_sel = 2'b11;
                b_sel = 2'b11;
            end
            OP_AUIPC: begin
                a_sel = 2'b01;
                b_sel = 2'b11;
            end
            default: ;
        endcase
    end

    // EX ALU op and branch condition
    always_comb begin
        alu_mode    = 4'b0000;
        branch_cond = 2'b00;
        case (op1)
            OP_R: alu_mode = {b30_1, f3_1};
            OP_I1: begin
                if (f3_1 == 3'b101)
                    alu_mode = {b30_1, f3_1};
                else
                    alu_mode = {1'b0, f3_1};
            end
            OP_B: begin
                unique case (1'b1)
                    f3_1[2:1] == 2'b10: alu_mode = 4'b0010;
                    f3_1[2:1] == 2'b11: alu_mode = 4'b0011;
                    default:            alu_mode = 4'b1000;
                endcase
                if (f3_1 == 3'b001 || f3_1 == 3'b100 ||
                    f3_1 == 3'b110)
                    branch_cond = 2'b01;
                else
                    branch_cond = 2'b10;
            end
            OP_JALR, OP_JAL: branch_cond = 2'b11;
            default: ;
        endcase
    end

    // MEM data cache control
    always_comb begin
        dcache_en = 1'b0;
        dcache_rw = 1'b0;
        data_mode = 3'b000;
        if (op2 == OP_LD) begin
            dcache_en = 1'b1;
            data_mode = f3_2;
        end else if (op2 == OP_S) begin
            dcache_en = 1'b1;
            dcache_rw = 1'b1;
            data_mode = f3_2;
        end
    end

    // WB register write
    always_comb begin
        wbe   = 1'b0;
        wbs   = 3'b000;
        wb_rd = 5'd0;
        if (writer_op(opw) && rd_w != 5'd0) begin
            wbe   = 1'b1;
            wb_rd = rd_w;
            wbs   = (opw == OP_LD) ? f3_w : 3'b011;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_scoreboard.sv
// Bench for pipe_ctrl_scoreboard: decode table, directed
// hazard/flush/reset sequences, randomized run vs pipeline model.
module tb_pipe_ctrl_scoreboard;

    localparam int S  = 4;
    localparam int BR = 1;
`ifdef PIPE_FWD_EN
    localparam int ALU_STALLS = 0;
    localparam int LU_STALLS  = 1;
`else
    localparam int ALU_STALLS = S-1;
    localparam int LU_STALLS  = S-1;
`endif

    localparam logic [31:0] ADDI1  = 32'h00500093;
    localparam logic [31:0] ADDI2  = 32'h00600113;
    localparam logic [31:0] ADD21  = 32'h00108133;
    localparam logic [31:0] LW3    = 32'h00002183;
    localparam logic [31:0] ADD43  = 32'h00318233;
    localparam logic [31:0] ADDI0  = 32'h00000013;
    localparam logic [31:0] ADD0   = 32'h00000033;
    localparam logic [31:0] ADDI5  = 32'h00500293;
    localparam logic [31:0] LUI5   = 32'h000012b7;
    localparam logic [31:0] BEQ    = 32'h00000463;
    localparam logic [31:0] BAD    = 32'h0000007f;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ins_valid = 1'b0;
    logic [31:0] ins = 32'd0;
    logic        ins_ready;
    logic        branch_taken = 1'b0;
    logic        flush;
    logic        illegal_ins;
    logic [2:0]  immode;
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;
    logic [3:0]  alu_mode;
    logic [1:0]  branch_cond;
    logic [2:0]  data_mode;
    logic        dcache_en;
    logic        dcache_rw;
    logic [2:0]  wbs;
    logic        wbe;
    logic [4:0]  wb_rd;

    pipe_ctrl_scoreboard #(.STAGES(S), .BR_STAGE(BR)) dut (
        .clk(clk), .rstn(rstn),
        .ins_valid(ins_valid), .ins(ins),
        .ins_ready(ins_ready),
        .branch_taken(branch_taken), .flush(flush),
        .illegal_ins(illegal_ins), .immode(immode),
        .a_sel(a_sel), .b_sel(b_sel),
        .alu_mode(alu_mode), .branch_cond(branch_cond),
        .data_mode(data_mode), .dcache_en(dcache_en),
        .dcache_rw(dcache_rw), .wbs(wbs), .wbe(wbe),
        .wb_rd(wb_rd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {
        K_R, K_ALUI, K_LOAD, K_JALR, K_STORE, K_BR,
        K_LUI, K_AUIPC, K_JAL, K_NOP, K_BAD
    } kind_e;

    typedef struct packed {
        logic       v;
        logic [31:0] i;
    } slot_t;
    typedef slot_t pipe_t [S];

    typedef struct packed {
        logic       ready;
        logic       flush;
        logic       ill;
        logic [2:0] imm;
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] alu;
        logic [1:0] bc;
        logic [2:0] dm;
        logic       den;
        logic       drw;
        logic [2:0] wbs;
        logic       wbe;
        logic [4:0] rd;
    } out_t;

    pipe_t m;

    function automatic kind_e kind_of(input logic [31:0] i);
        case (i[6:0])
            7'b0110011: return K_R;
            7'b0010011: return K_ALUI;
            7'b0000011: return K_LOAD;
            7'b1100111: return K_JALR;
            7'b0100011: return K_STORE;
            7'b1100011: return K_BR;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            7'b1101111: return K_JAL;
            7'b0000000, 7'b0001111,
            7'b1110011: return K_NOP;
            default:    return K_BAD;
        endcase
    endfunction

    function automatic logic writes(input logic [31:0] i);
        kind_e k = kind_of(i);
        return (k inside {K_R, K_ALUI, K_LOAD, K_JALR,
                          K_LUI, K_AUIPC, K_JAL}) &&
               i[11:7] != 5'd0;
    endfunction

    function automatic logic reads_reg(input logic [31:0] i,
                                       input logic [4:0] r);
        kind_e k = kind_of(i);
        logic u1 = k inside {K_R, K_ALUI, K_LOAD, K_JALR,
                             K_STORE, K_BR};
        logic u2 = k inside {K_R, K_STORE, K_BR};
        return (u1 && i[19:15] == r) || (u2 && i[24:20] == r);
    endfunction

    function automatic out_t predict(input logic v,
                                     input logic [31:0] i,
                                     input logic br);
        out_t o;
        logic haz;
        logic [31:0] s0, s1, s2, sw;
        logic [2:0] f3;
        o = '0;
        haz = 1'b0;
        for (int k = 0; k < S-1; k++) begin
`ifdef PIPE_FWD_EN
            if (k == 0 && m[0].v && kind_of(m[0].i) == K_LOAD &&
                writes(m[0].i) && reads_reg(i, m[0].i[11:7]))
                haz = 1'b1;
`else
            if (m[k].v && writes(m[k].i) &&
                reads_reg(i, m[k].i[11:7]))
                haz = 1'b1;
`endif
        end
        haz = haz && v;
        o.flush = m[BR].v && br &&
                  (kind_of(m[BR].i) inside {K_BR, K_JALR, K_JAL});
        o.ready = !o.flush && !haz;
        o.ill = v && kind_of(i) == K_BAD;
        case (kind_of(i))
            K_R:                     o.imm = 3'd0;
            K_ALUI, K_LOAD, K_JALR:  o.imm = 3'd1;
            K_STORE:                 o.imm = 3'd2;
            K_BR:                    o.imm = 3'd3;
            K_LUI, K_AUIPC:          o.imm = 3'd4;
            K_JAL:                   o.imm = 3'd5;
            default:                 o.imm = 3'd0;
        endcase
        s0 = m[0].v ? m[0].i : 32'd0;
        s1 = m[1].v ? m[1].i : 32'd0;
        s2 = m[2].v ? m[2].i : 32'd0;
        sw = m[S-1].v ? m[S-1].i : 32'd0;
        case (kind_of(s0))
            K_ALUI:        o.b = 2'b01;
            K_JALR, K_JAL: begin o.a = 2'b01; o.b = 2'b10; end
            K_LUI:         begin o.a = 2'b11; o.b = 2'b11; end
            K_AUIPC:       begin o.a = 2'b01; o.b = 2'b11; end
            default: ;
        endcase
        f3 = s1[14:12];
        case (kind_of(s1))
            K_R:    o.alu = {s1[30], f3};
            K_ALUI: o.alu = (f3 == 3'd5) ? {s1[30], f3}
                                         : {1'b0, f3};
            K_BR: begin
                if (f3 == 3'd4 || f3 == 3'd5)      o.alu = 4'd2;
                else if (f3 == 3'd6 || f3 == 3'd7) o.alu = 4'd3;
                else                               o.alu = 4'd8;
                o.bc = (f3 inside {3'd1, 3'd4, 3'd6}) ? 2'b01
                                                      : 2'b10;
            end
            K_JALR, K_JAL: o.bc = 2'b11;
            default: ;
        endcase
        if (kind_of(s2) == K_LOAD) begin
            o.den = 1'b1; o.dm = s2[14:12];
        end else if (kind_of(s2) == K_STORE) begin
            o.den = 1'b1; o.drw = 1'b1; o.dm = s2[14:12];
        end
        if (writes(sw)) begin
            o.wbe = 1'b1;
            o.rd  = sw[11:7];
            o.wbs = (kind_of(sw) == K_LOAD) ? sw[14:12] : 3'b011;
        end
        return o;
    endfunction

    function automatic pipe_t next_pipe(input logic v,
                                        input logic [31:0] i,
                                        input logic br);
        pipe_t n;
        out_t o = predict(v, i, br);
        for (int k = S-1; k > 0; k--) begin
            n[k] = m[k-1];
            if (o.flush && k <= BR) n[k].v = 1'b0;
        end
        n[0].v = o.ready && v && kind_of(i) != K_BAD;
        n[0].i = i;
        return n;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) m <= '{default: '0};
        else       m <= next_pipe(ins_valid, ins, branch_taken);
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] dut_outs();
        return {ins_ready, flush, illegal_ins, immode, a_sel,
                b_sel, alu_mode, branch_cond, data_mode,
                dcache_en, dcache_rw, wbs, wbe, wb_rd};
    endfunction

    task automatic drive(input logic v, input logic [31:0] i,
                         input logic br);
        @(negedge clk);
        ins_valid = v;
        ins = i;
        branch_taken = br;
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rstn = 1'b0;
        ins_valid = 1'b0;
        ins = 32'd0;
        branch_taken = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic feed(input string nm, input logic [31:0] i,
                        output int stalls);
        logic ok = 1'b0;
        stalls = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            drive(1'b1, i, 1'b0);
            if (ins_ready) ok = 1'b1;
            else stalls++;
        end
        chk({nm, "_accept"}, 32'(ok), 32'd1);
    endtask

    task automatic wb_quiet(input string nm, input int cycles);
        int hits = 0;
        for (int j = 0; j < cycles; j++) begin
            drive(1'b0, 32'd0, 1'b0);
            if (wbe) hits++;
        end
        chk(nm, hits, 0);
    endtask

    function automatic logic [31:0] rand_ins();
        logic [6:0] ops [13] = '{
            7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
            7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
            7'b1101111, 7'b0000000, 7'b0001111, 7'b1110011,
            7'b1111111};
        logic [31:0] i = $urandom;
        i[6:0]   = ops[$urandom_range(0, 12)];
        i[11:7]  = 5'($urandom_range(0, 3));
        i[19:15] = 5'($urandom_range(0, 3));
        i[24:20] = 5'($urandom_range(0, 3));
        return i;
    endfunction

    typedef struct {
        logic [31:0] i;
        logic        v;
        logic [2:0]  imm;
        logic        ill;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        out_t exp_o;

        tbl[0]  = '{ADD21,        1'b1, 3'd0, 1'b0};
        tbl[1]  = '{ADDI1,        1'b1, 3'd1, 1'b0};
        tbl[2]  = '{LW3,          1'b1, 3'd1, 1'b0};
        tbl[3]  = '{32'h000080e7, 1'b1, 3'd1, 1'b0};
        tbl[4]  = '{32'h00112023, 1'b1, 3'd2, 1'b0};
        tbl[5]  = '{BEQ,          1'b1, 3'd3, 1'b0};
        tbl[6]  = '{LUI5,         1'b1, 3'd4, 1'b0};
        tbl[7]  = '{32'h00001297, 1'b1, 3'd4, 1'b0};
        tbl[8]  = '{32'h0080006f, 1'b1, 3'd5, 1'b0};
        tbl[9]  = '{32'h0000000f, 1'b1, 3'd0, 1'b0};
        tbl[10] = '{32'h00000073, 1'b1, 3'd0, 1'b0};
        tbl[11] = '{BAD,          1'b1, 3'd0, 1'b1};
        tbl[12] = '{BAD,          1'b0, 3'd0, 1'b0};

        // reset state
        #3;
        chk("rst_ready", 32'(ins_ready), 32'd1);
        chk("rst_outs", dut_outs() & 32'h1fffffff, 32'd0);
        reset_dut();

        // decode table
        foreach (tbl[n]) begin
            drive(tbl[n].v, tbl[n].i, 1'b0);
            chk($sformatf("immode_%0d", n), 32'(immode),
                32'(tbl[n].imm));
            chk($sformatf("illegal_%0d", n), 32'(illegal_ins),
                32'(tbl[n].ill));
        end

        // reset and fill
        reset_dut();
        drive(1'b1, ADDI1, 1'b0);
        chk("fill_accept", 32'(ins_ready), 32'd1);
        for (int j = 1; j <= S; j++) begin
            drive(1'b0, 32'd0, 1'b0);
            chk("fill_ready", 32'(ins_ready), 32'd1);
            if (j == S-1) chk("fill_early_wbe", 32'(wbe), 32'd0);
        end
        chk("fill_wbe", 32'(wbe), 32'd1);
        chk("fill_rd", 32'(wb_rd), 32'd1);
        chk("fill_wbs", 32'(wbs), 32'd3);

        // ALU RAW hazard
        reset_dut();
        drive(1'b1, ADDI1, 1'b0);
        feed("raw", ADD21, st);
        chk("raw_stalls", st, ALU_STALLS);

        // load reaches MEM
        reset_dut();
        drive(1'b1, LW3, 1'b0);
        for (int j = 0; j < 3; j++) drive(1'b0, 32'd0, 1'b0);
        chk("lw_den", 32'(dcache_en), 32'd1);
        chk("lw_drw", 32'(dcache_rw), 32'd0);
        chk("lw_dm", 32'(data_mode), 32'd2);

        // load-use
        reset_dut();
        drive(1'b1, LW3, 1'b0);
        feed("lu", ADD43, st);
        chk("lu_stalls", st, LU_STALLS);

        // no false hazards
        reset_dut();
        drive(1'b1, ADDI0, 1'b0);
        feed("x0", ADD0, st);
        chk("x0_stalls", st, 0);
        reset_dut();
        drive(1'b1, ADDI5, 1'b0);
        feed("lui", LUI5, st);
        chk("lui_stalls", st, 0);

        // taken branch flush
        reset_dut();
        drive(1'b1, BEQ, 1'b0);
        drive(1'b1, ADDI1, 1'b0);
        drive(1'b1, ADDI2, 1'b1);
        chk("br_flush", 32'(flush), 32'd1);
        chk("br_cond", 32'(branch_cond), 32'd2);
        chk("br_ready", 32'(ins_ready), 32'd0);
        drive(1'b0, 32'd0, 1'b0);
        chk("br_flush_off", 32'(flush), 32'd0);
        wb_quiet("br_no_wb", S+2);

        // flush wins over a pending hazard
        reset_dut();
        drive(1'b1, BEQ, 1'b0);
        drive(1'b1, LW3, 1'b0);
        drive(1'b1, ADD43, 1'b1);
        chk("brhz_flush", 32'(flush), 32'd1);
        chk("brhz_ready", 32'(ins_ready), 32'd0);
        wb_quiet("brhz_no_wb", S+2);

        // async reset mid-stream
        reset_dut();
        drive(1'b1, LW3, 1'b0);
        drive(1'b1, ADDI1, 1'b0);
        drive(1'b1, BEQ, 1'b0);
        drive(1'b0, 32'd0, 1'b0);
        chk("mid_den", 32'(dcache_en), 32'd1);
        #1;
        rstn = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(ins_ready), 32'd1);
        chk("mid_rst_outs", dut_outs() & 32'h1fffffff, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        drive(1'b1, BAD, 1'b0);
        chk("bad_ill", 32'(illegal_ins), 32'd1);
        chk("bad_ready", 32'(ins_ready), 32'd1);
        wb_quiet("bad_no_wb", S+1);

        // randomized run against the model
        reset_dut();
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            ins_valid = ($urandom_range(0, 3) != 0);
            ins = rand_ins();
            branch_taken = ($urandom_range(0, 2) == 0);
            #1;
            exp_o = predict(ins_valid, ins, branch_taken);
            chk($sformatf("rand_%0d", n), dut_outs(),
                32'(exp_o));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_scoreboard.md
Name: pipe_ctrl_scoreboard

Overview:
Parametrised RV32I pipeline control unit. Tracks in-flight instructions through ID..WB and decodes per-stage control fields. Detects RAW hazards by comparing true source registers only, with rd!=x0 exclusion. Handles predict-not-taken branch flush. Sits between fetch (consumes `ins`, drives `ins_ready`) and the datapath (mux selects, ALU mode, dcache, writeback).

Parameters:
- STAGES, 4, pipeline stages after fetch; min 4. stage[0]=ID, stage[1]=EX, stage[2..STAGES-2]=MEM, stage[STAGES-1]=WB.
- BR_STAGE, 1, stage index where `branch_taken` is sampled; 1 <= BR_STAGE <= STAGES-2.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- ins_valid  in  1  fetch presents an instruction
- ins  in  32  fetched instruction
- ins_ready  out  1  instruction accepted this cycle (replaces pc_en)
- branch_taken  in  1  datapath: control transfer in stage[BR_STAGE] is taken
- flush  out  1  redirect pulse to fetch
- illegal_ins  out  1  accepted opcode is not a known RV32I major opcode
- immode  out  3  immediate format of `ins`: R=0, I=1, S=2, B=3, U=4, J=5, other=0
- a_sel  out  2  stage[0] operand-A select
- b_sel  out  2  stage[0] operand-B select
- alu_mode  out  4  stage[1] ALU op
- branch_cond  out  2  stage[1] branch condition
- data_mode  out  3  stage[2] funct3 for load/store
- dcache_en  out  1  stage[2] memory access
- dcache_rw  out  1  stage[2] 1=store
- wbs  out  3  WB source select
- wbe  out  1  WB register write enable
- wb_rd  out  5  WB destination register

Behaviour:
- **State.** Each stage k holds ins_k[31:0] and v_k.
  - Invalid stage decodes as NOP: all its outputs are 0.
  - Reset: all v_k=0, all ins_k=0.
  - Reset values: every output 0 except ins_ready=1.
- **Writer.** Opcode in {R, I_1=0010011, I_2 load, I_3 JALR, U1, U2, J} and rd!=0.
- **Sources.**
  - rs1 used by R, I_1, I_2, I_3, S, B.
  - rs2 used by R, S, B.
  - U and J use no sources. rd of the incoming instruction is never compared.
- **hazard.** ins_valid, AND some valid stage k in 0..STAGES-2 is a writer, AND its rd equals a used source of `ins`. WB (last stage) writes before read, so it is excluded.
- **Advance** (every cycle, combinational control):
  - flush = v_BR AND stage[BR_STAGE] opcode in {B, I_3, J} AND branch_taken.
  - flush=1:
    - v_0..v_BR become 0 on the next edge.
    - Older stages advance normally.
    - `ins` is discarded; ins_ready=0.
    - flush has priority over hazard.
  - hazard=1, no flush:
    - ins_ready=0.
    - A bubble (v=0) is inserted into stage[0].
    - All older stages advance.
  - Otherwise:
    - ins_ready = 1.
    - stage[0] <= {ins, ins_valid AND opcode legal}.
    - All older stages shift by one.
- **Illegal opcode.** illegal_ins=1 only when ins_valid and the opcode is not legal. The instruction is accepted as a bubble. Opcodes 0000000, 0001111 and 1110011 are legal NOPs: v=1, no writes, no memory access.
- **ID decode.**
  - R/I_2/S/B/NOP: a_sel=00, b_sel=00.
  - I_1: a_sel=00, b_sel=01.
  - I_3/J: a_sel=01, b_sel=10.
  - U1: a_sel=11, b_sel=11. U2: a_sel=01, b_sel=11.
- **alu_mode (EX).**
  - R: {f7[5], f3}.
  - I_1: f3=101 gives {f7[5], f3}, else {0, f3}.
  - B: f3 in {100,101} gives 0010; f3 in {110,111} gives 0011; else 1000.
  - Others: 0000.
- **branch_cond (EX).**
  - B with f3 in {001,100,110}: 01.
  - Other B: 10.
  - I_3 and J: 11.
  - Otherwise: 00.
- **MEM.**
  - I_2: dcache_en=1, dcache_rw=0, data_mode=f3.
  - S: dcache_en=1, dcache_rw=1, data_mode=f3.
  - Else all 0.
- **WB.**
  - Writer: wbe=1, wb_rd=rd, wbs = f3 for I_2, else 011.
  - Non-writer: wbe=0, wbs=000, wb_rd=0.
- **Mid-operation reset.** Reset mid-operation clears all stages immediately; no partial state survives.

Optional Feature:
- Macro: `PIPE_FWD_EN`.
- Defined: the datapath forwards from EX/MEM/WB. hazard reduces to load-use only: stage[0] is I_2, is a writer, and its rd matches a used source of `ins`. Exactly one bubble is inserted.
- Undefined: full scoreboard hazard as described in Behaviour.

Test Plan:
1. **Reset and fill.** Reset, then feed 0x00500093 (addi x1,x0,5).
   - ins_ready=1 throughout.
   - At STAGES cycles after acceptance: wbe=1, wb_rd=1, wbs=011.
2. **ALU RAW hazard.** 0x00500093 then 0x00108133 (add x2,x1,x1).
   - Without PIPE_FWD_EN: ins_ready=0 for STAGES-1 cycles.
   - With PIPE_FWD_EN: ins_ready stays 1 (0 stall cycles).
3. **Load-use.** 0x00002183 (lw x3) then 0x00318233 (add x4,x3,x3).
   - With PIPE_FWD_EN: exactly 1 stall cycle.
   - Stage[2] for the lw: dcache_en=1, dcache_rw=0, data_mode=010.
4. **No false hazards.**
   - x0 destination: 0x00000013 (addi x0,x0,0) then 0x00000033 (add x0,x0,x0) gives 0 stalls.
   - U-type after a writer: 0x000012b7 (lui x5) following a writer of x5 gives 0 stalls.
5. **Taken branch flush.** 0x00000463 (beq x0,x0,8), then two addi; assert branch_taken when the beq is in stage[BR_STAGE].
   - flush=1 for one cycle; branch_cond=10.
   - The younger instructions never produce wbe=1.
   - Same cycle with a hazard pending: the flush still occurs.
6. **Async reset mid-stream.** Assert rstn=0 mid-stream.
   - Outputs go to reset values before the next clk edge.
   - Illegal 0x0000007f gives illegal_ins=1 and no WB.
